// File: rtl/conv3x3_multich_accum.sv
// conv3x3_multich_accum
//   Streams a square NUM_CH-channel image in raster order. For every interior
//   pixel it computes one output featuremap value: a 3x3 window per channel,
//   each tap multiplied by a runtime-loaded weight, all products summed, then
//   bias added, rescaled by FRAC_BITS and saturated. Fixed 3-cycle latency.
//
//   Optional build macro: LEAKY_RELU_EN -- applies a leaky ReLU (slope 1/8)
//   to the saturated result. Without it the output is linear.
//
// Ports
//   Clk         clock, rising edge
//   Rst         synchronous active-high reset
//   data_in     one pixel per channel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in    data_in beat accepted this cycle
//   wt_wr_en    weight/bias write strobe
//   wt_wr_addr  channel*9+tap for a weight, 9*NUM_CH for the bias
//   wt_wr_data  signed weight/bias value
//   data_out    signed result pixel (held while valid_out is low)
//   valid_out   one-cycle pulse per result
//   frame_done  pulses with the last result of a frame
//   wt_err      pulses the cycle after a rejected weight write
module conv3x3_multich_accum #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned IMG_SIZE   = 104,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
    input  logic                           valid_in,
    input  logic                           wt_wr_en,
    input  logic [$clog2(9*NUM_CH+1)-1:0]  wt_wr_addr,
    input  logic [DATA_WIDTH-1:0]          wt_wr_data,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           valid_out,
    output logic                           frame_done,
    output logic                           wt_err
);

    localparam int unsigned NUM_TAPS = 9 * NUM_CH;
    localparam int unsigned ADDR_W   = $clog2(NUM_TAPS + 1);
    localparam int unsigned PROD_W   = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W    = PROD_W + $clog2(NUM_TAPS);
    // One extra bit so adding the scaled bias can never wrap.
    localparam int unsigned SUM_W    = ACC_W + 1;
    localparam int unsigned CNT_W    = $clog2(IMG_SIZE);

    localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]              r_row;
    logic [CNT_W-1:0]              r_col;
    logic signed [DATA_WIDTH-1:0]  r_lb0 [NUM_CH][IMG_SIZE];
    logic signed [DATA_WIDTH-1:0]  r_lb1 [NUM_CH][IMG_SIZE];
    logic signed [DATA_WIDTH-1:0]  r_win [NUM_CH][9];
    logic signed [DATA_WIDTH-1:0]  r_wt  [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  r_bias;
    logic signed [PROD_W-1:0]      r_prod [NUM_TAPS];
    logic signed [ACC_W-1:0]       r_acc;
    logic                          r_v1, r_v2;
    logic                          r_last1, r_last2;

    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_win_ok;
    logic                          w_idle;
    logic                          w_wr_ok;
    logic signed [DATA_WIDTH-1:0]  w_win_nxt [NUM_CH][9];
    logic signed [ACC_W-1:0]       w_sum;
    logic signed [SUM_W-1:0]       w_biased;
    logic signed [SUM_W-1:0]       w_shift;
    logic signed [DATA_WIDTH-1:0]  w_sat;
    logic signed [DATA_WIDTH-1:0]  w_res;

    assign w_col_last = (r_col == CNT_W'(IMG_SIZE - 1));
    assign w_row_last = (r_row == CNT_W'(IMG_SIZE - 1));
    assign w_win_ok   = valid_in && (r_row >= CNT_W'(2)) && (r_col >= CNT_W'(2));
    // Writes only between frames with nothing left in the pipeline.
    assign w_idle     = (r_row == '0) && (r_col == '0) && !r_v1 && !r_v2 && !valid_out;
    assign w_wr_ok    = wt_wr_en && w_idle && (wt_wr_addr <= ADDR_W'(NUM_TAPS));

    // Raster position of the beat currently on data_in.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    // Line buffers indexed by column: lb0 holds row-1, lb1 holds row-2.
    // Not reset; the row>=2 qualifier keeps stale contents out of results.
    always_ff @(posedge Clk) begin
        if (valid_in) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                r_lb1[ch][r_col] <= r_lb0[ch][r_col];
                r_lb0[ch][r_col] <= data_in[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Window after shifting in the incoming column; S1 consumes it directly.
    always_comb begin
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            for (int r = 0; r < 3; r++) begin
                w_win_nxt[ch][r*3]   = r_win[ch][r*3+1];
                w_win_nxt[ch][r*3+1] = r_win[ch][r*3+2];
            end
            w_win_nxt[ch][2] = r_lb1[ch][r_col];
            w_win_nxt[ch][5] = r_lb0[ch][r_col];
            w_win_nxt[ch][8] = data_in[ch*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++)
                for (int t = 0; t < 9; t++)
                    r_win[ch][t] <= '0;
        end else if (valid_in) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++)
                for (int t = 0; t < 9; t++)
                    r_win[ch][t] <= w_win_nxt[ch][t];
        end
    end

    // Weight and bias storage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < int'(NUM_TAPS); i++)
                r_wt[i] <= '0;
            r_bias <= '0;
            wt_err <= 1'b0;
        end else begin
            wt_err <= wt_wr_en && !w_wr_ok;
            if (w_wr_ok) begin
                if (wt_wr_addr == ADDR_W'(NUM_TAPS))
                    r_bias <= wt_wr_data;
                for (int i = 0; i < int'(NUM_TAPS); i++)
                    if (wt_wr_addr == ADDR_W'(i))
                        r_wt[i] <= wt_wr_data;
            end
        end
    end

    // S1: per-tap products.
    always_ff @(posedge Clk) begin
        for (int ch = 0; ch < int'(NUM_CH); ch++)
            for (int t = 0; t < 9; t++)
                r_prod[ch*9+t] <= PROD_W'(w_win_nxt[ch][t]) * PROD_W'(r_wt[ch*9+t]);
    end

    // S2: sign-extended sum of all products.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(NUM_TAPS); i++)
            w_sum = w_sum + ACC_W'(r_prod[i]);
    end

    always_ff @(posedge Clk) begin
        r_acc <= w_sum;
    end

    // S3: bias, rescale (floor), saturate, optional leaky ReLU.
    always_comb begin
        w_biased = SUM_W'(r_acc) + (SUM_W'(r_bias) <<< FRAC_BITS);
        w_shift  = w_biased >>> FRAC_BITS;
        if (w_shift > SUM_W'(D_MAX))
            w_sat = D_MAX;
        else if (w_shift < SUM_W'(D_MIN))
            w_sat = D_MIN;
        else
            w_sat = DATA_WIDTH'(w_shift);
`ifdef LEAKY_RELU_EN
        w_res = w_sat[DATA_WIDTH-1] ? (w_sat >>> 3) : w_sat;
`else
        w_res = w_sat;
`endif
    end

    // Token pipeline and output register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_last1    <= 1'b0;
            r_last2    <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            r_v1       <= w_win_ok;
            r_last1    <= w_win_ok && w_row_last && w_col_last;
            r_v2       <= r_v1;
            r_last2    <= r_last1;
            valid_out  <= r_v2;
            frame_done <= r_v2 && r_last2;
            if (r_v2)
                data_out <= w_res;
        end
    end

endmodule

// File: tb/tb_conv3x3_multich_accum.sv
// Self-checking bench for conv3x3_multich_accum (NUM_CH=2, IMG_SIZE=4).
// Expected results come from a behavioural reference convolution and are
// queued per qualifying beat; observed results are queued by a monitor.
module tb_conv3x3_multich_accum;

    localparam int unsigned NCH = 2;
    localparam int unsigned IMG = 4;
    localparam int unsigned DW  = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [31:0] cyc;
    } res_t;

    logic              Clk;
    logic              Rst;
    logic [NCH*DW-1:0] data_in;
    logic              valid_in;
    logic              wt_wr_en;
    logic [4:0]        wt_wr_addr;
    logic [DW-1:0]     wt_wr_data;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic              frame_done;
    logic              wt_err;

    conv3x3_multich_accum #(
        .NUM_CH    (NCH),
        .IMG_SIZE  (IMG),
        .DATA_WIDTH(DW),
        .FRAC_BITS (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .wt_wr_en  (wt_wr_en),
        .wt_wr_addr(wt_wr_addr),
        .wt_wr_data(wt_wr_data),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_done(frame_done),
        .wt_err    (wt_err)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tb_row   = 0;
    int   tb_col   = 0;
    int   img [2][16];
    int   m_wt [19];
    int   m_bias;
    res_t exp_q [$];
    res_t obs_q [$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk)
        if (valid_out) obs_q.push_back({data_out, frame_done, 32'(cyc)});

    // Reference: full-precision 3x3 convolution ending at (r,c).
    function automatic logic [15:0] model_out(int r, int c);
        longint acc = 0;
        for (int ch = 0; ch < 2; ch++)
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    acc += longint'(img[ch][(r-2+dr)*4 + (c-2+dc)]) * longint'(m_wt[ch*9+dr*3+dc]);
        acc += longint'(m_bias) * 256;
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef LEAKY_RELU_EN
        if (acc < 0) acc = acc >>> 3;
`endif
        return 16'(acc);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 19; i++) m_wt[i] = 0;
        m_bias = 0;
        tb_row = 0;
        tb_col = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    // One beat; queues the expected result when the beat completes a window.
    task automatic drive_beat(input logic [15:0] p0, input logic [15:0] p1, input int gap);
        res_t e;
        data_in  = {p1, p0};
        valid_in = 1'b1;
        img[0][tb_row*4+tb_col] = int'($signed(p0));
        img[1][tb_row*4+tb_col] = int'($signed(p1));
        if (tb_row >= 2 && tb_col >= 2) begin
            e.data = model_out(tb_row, tb_col);
            e.last = (tb_row == 3 && tb_col == 3);
            e.cyc  = 32'(cyc + 3);
            exp_q.push_back(e);
        end
        if (tb_col == 3) begin
            tb_col = 0;
            tb_row = (tb_row == 3) ? 0 : tb_row + 1;
        end else begin
            tb_col = tb_col + 1;
        end
        @(posedge Clk); #1;
        valid_in = 1'b0;
        idle(gap);
    endtask

    task automatic wr_wt(input logic [4:0] addr, input logic [15:0] d, input logic exp_err);
        wt_wr_en   = 1'b1;
        wt_wr_addr = addr;
        wt_wr_data = d;
        @(posedge Clk); #1;
        wt_wr_en = 1'b0;
        n_checks++;
        if (wt_err !== exp_err) begin
            n_fail++;
            $display("FAIL wt_err addr=%0d: got %b expected %b", addr, wt_err, exp_err);
        end
        if (!exp_err) begin
            if (addr == 5'd18) m_bias = int'($signed(d));
            else m_wt[addr] = int'($signed(d));
        end
    endtask

    task automatic load_weights(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b);
        for (int i = 0; i < 9; i++) wr_wt(5'(i), w0, 1'b0);
        for (int i = 9; i < 18; i++) wr_wt(5'(i), w1, 1'b0);
        wr_wt(5'd18, b, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({data_out, valid_out, frame_done, wt_err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h/%b/%b/%b expected 0/0/0/0",
                     data_out, valid_out, frame_done, wt_err);
        end
    endtask

    task automatic test_sum_ch0();
        res_t e, o;
        logic [15:0] last_v = 16'h0;
        load_weights(16'h0100, 16'h0000, 16'h0000);
        for (int n = 0; n < 16; n++) drive_beat(16'h0100, 16'h0300, 0);
        idle(6);
        n_checks++;
        if (exp_q.size() != 4 || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL sum_ch0 count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++; last_v = e.data;
            if (o !== e || e.data !== 16'h0900) begin
                n_fail++;
                $display("FAIL sum_ch0 result: got %h expected %h (data/last/cycle)", o, e);
            end
        end
        n_checks++;
        if (data_out !== last_v) begin
            n_fail++;
            $display("FAIL sum_ch0 hold: got %h expected %h", data_out, last_v);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_center_tap();
        res_t e, o;
        load_weights(16'h0000, 16'h0000, 16'h0000);
        wr_wt(5'd13, 16'h0100, 1'b0);
        for (int n = 0; n < 16; n++) drive_beat(16'($urandom_range(0, 65535)), 16'(n << 8), 0);
        idle(6);
        n_checks++;
        if (exp_q.size() != obs_q.size()) begin
            n_fail++;
            $display("FAIL center count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL center result: got %h expected %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        res_t e, o;
        logic [15:0] wv [3];
        logic [15:0] pv [3];
        wv[0] = 16'h7FFF; pv[0] = 16'h7FFF;
        wv[1] = 16'h8000; pv[1] = 16'h8000;
        wv[2] = 16'h7FFF; pv[2] = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            load_weights(wv[k], wv[k], 16'h0000);
            for (int n = 0; n < 16; n++) drive_beat(pv[k], pv[k], 0);
            idle(6);
            n_checks++;
            if (exp_q.size() != 4 || obs_q.size() != 4) begin
                n_fail++;
                $display("FAIL sat%0d count: got %0d expected %0d", k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sat%0d result: got %h expected %h", k, o, e);
                end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_bias();
        res_t e, o;
        load_weights(16'h0000, 16'h0000, 16'hFF00);
        for (int n = 0; n < 16; n++) drive_beat(16'h1234, 16'h4321, 0);
        idle(6);
        n_checks++;
        if (exp_q.size() != 4 || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL bias count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bias result: got %h expected %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_gaps();
        res_t e, o;
        load_weights(16'h0100, 16'h0000, 16'h0000);
        for (int n = 0; n < 16; n++) drive_beat(16'h0100, 16'h0300, 2);
        idle(6);
        n_checks++;
        if (exp_q.size() != 4 || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL gaps count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL gaps result: got %h expected %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wt_err();
        res_t e, o;
        load_weights(16'h0100, 16'h0000, 16'h0000);
        wr_wt(5'd19, 16'h7FFF, 1'b1);
        wr_wt(5'd31, 16'h7FFF, 1'b1);
        for (int n = 0; n < 5; n++) drive_beat(16'h0100, 16'h0300, 0);
        wr_wt(5'd0, 16'h7FFF, 1'b1);
        for (int n = 5; n < 16; n++) drive_beat(16'h0100, 16'h0300, 0);
        // Counters already wrapped, but results are still in flight.
        wr_wt(5'd1, 16'h7FFF, 1'b1);
        idle(6);
        n_checks++;
        if (exp_q.size() != 4 || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL wt_err count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e || e.data !== 16'h0900) begin
                n_fail++;
                $display("FAIL wt_err result: got %h expected %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        load_weights(16'h0100, 16'h0000, 16'h0100);
        // Beat 10 completes the first window; its result is in S1 at reset.
        for (int n = 0; n < 11; n++) drive_beat(16'h0100, 16'h0300, 0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        exp_q.delete();
        clear_model();
        idle(5);
        n_checks++;
        if (obs_q.size() != 0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid drop: got %0d results expected 0", obs_q.size());
        end
        obs_q.delete();
        for (int n = 0; n < 16; n++) drive_beat(16'h0100, 16'h0300, 0);
        idle(6);
        n_checks++;
        if (exp_q.size() != 4 || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL reset_mid count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e || e.data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_mid result: got %h expected %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        Rst        = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        wt_wr_en   = 1'b0;
        wt_wr_addr = '0;
        wt_wr_data = '0;
        clear_model();
        for (int i = 0; i < 16; i++) begin img[0][i] = 0; img[1][i] = 0; end
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        test_reset();
        test_sum_ch0();
        test_center_tap();
        test_saturation();
        test_bias();
        test_gaps();
        test_wt_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
